// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: writable control store, micro-PC, return stack.
// Optional moc watchdog enabled by defining MOC_WATCHDOG_EN.
module micro_sequencer #(
    parameter int          CW_W        = 48,
    parameter int          UADDR_W     = 8,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned DEC_BASE    = 32'h0000_0040,
    parameter int          TIMEOUT     = 64
) (
    input  logic                        CLK,
    input  logic                        CLR,
    input  logic                        moc,
    input  logic [31:0]                 ir,
    input  logic [3:0]                  flags,
    input  logic                        ld_en,
    input  logic [UADDR_W-1:0]          ld_addr,
    input  logic [CW_W+UADDR_W+3-1:0]   ld_data,
    output logic [CW_W-1:0]             ctrl,
    output logic [UADDR_W-1:0]          upc,
    output logic                        stack_err,
    output logic                        moc_err
);

    localparam int IW    = CW_W + UADDR_W + 3;
    localparam int DEPTH = 1 << UADDR_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_INC    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_DECODE = 3'd2,
        OP_WAIT   = 3'd3,
        OP_CSKIP  = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_FETCH  = 3'd7
    } op_e;

    if ((STACK_DEPTH < 1) || (TIMEOUT < 1)) begin : g_bad_param
        $error("micro_sequencer: STACK_DEPTH and TIMEOUT must be at least 1");
    end

    logic [IW-1:0]      store_mem [0:DEPTH-1];
    logic [UADDR_W-1:0] stack_mem [0:(1<<SP_W)-1];

    logic [UADDR_W-1:0] upc_r;
    logic [SP_W-1:0]    sp_r;
    logic               stack_err_r;
    logic               moc_err_r;

    logic [IW-1:0]      word_s;
    op_e                op_s;
    logic [UADDR_W-1:0] next_s;
    logic [UADDR_W-1:0] upc_inc_s;
    logic [UADDR_W-1:0] dec_target_s;
    logic [UADDR_W-1:0] upc_next_s;
    logic [SP_W-1:0]    sp_next_s;
    logic               push_s;
    logic               stack_err_set_s;
    logic               moc_err_set_s;
    logic [CW_W-1:0]    ctrl_s;
    logic               unused_ir_s;

    // ARM condition-code evaluation; flags are {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign word_s       = store_mem[upc_r];
    assign op_s         = op_e'(word_s[IW-1 -: 3]);
    assign next_s       = word_s[CW_W +: UADDR_W];
    assign upc_inc_s    = upc_r + UADDR_W'(1);
    assign dec_target_s = UADDR_W'(DEC_BASE) + UADDR_W'(ir[27:20]);
    assign unused_ir_s  = ^ir[19:0];

    // Control-store write port; the store is never cleared by reset.
    always_ff @(posedge CLK) begin
        if (ld_en) begin
            store_mem[ld_addr] <= ld_data;
        end
    end

    // Return-stack push port.
    always_ff @(posedge CLK) begin
        if (!CLR && !ld_en && push_s) begin
            stack_mem[sp_r] <= upc_inc_s;
        end
    end

`ifdef MOC_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_r;
    logic [WD_W-1:0] wd_next_s;
    logic            trap_s;

    // Watchdog: counts stalled WAIT cycles; a moc on the expiry edge still wins.
    always_comb begin
        wd_next_s = '0;
        trap_s    = 1'b0;
        if ((op_s == OP_WAIT) && !moc) begin
            if (wd_r == WD_W'(TIMEOUT)) begin
                trap_s = 1'b1;
            end else begin
                wd_next_s = wd_r + WD_W'(1);
            end
        end else begin
            wd_next_s = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            wd_r <= '0;
        end else if (!ld_en) begin
            wd_r <= wd_next_s;
        end
    end
`else
    logic trap_s;
    assign trap_s = 1'b0;
`endif

    // Next-state logic for micro-PC and return stack.
    always_comb begin
        upc_next_s      = upc_inc_s;
        sp_next_s       = sp_r;
        push_s          = 1'b0;
        stack_err_set_s = 1'b0;
        moc_err_set_s   = 1'b0;
        case (op_s)
            OP_INC:    upc_next_s = upc_inc_s;
            OP_JUMP:   upc_next_s = next_s;
            OP_DECODE: upc_next_s = dec_target_s;
            OP_WAIT: begin
                if (moc) begin
                    upc_next_s = upc_inc_s;
                end else if (trap_s) begin
                    upc_next_s    = next_s;
                    moc_err_set_s = 1'b1;
                end else begin
                    upc_next_s = upc_r;
                end
            end
            OP_CSKIP: begin
                if (cond_pass(ir[31:28], flags)) begin
                    upc_next_s = upc_inc_s;
                end else begin
                    upc_next_s = next_s;
                end
            end
            OP_CALL: begin
                upc_next_s = next_s;
                if (sp_r == SP_W'(STACK_DEPTH)) begin
                    stack_err_set_s = 1'b1;
                end else begin
                    push_s    = 1'b1;
                    sp_next_s = sp_r + SP_W'(1);
                end
            end
            OP_RET: begin
                if (sp_r == '0) begin
                    upc_next_s      = '0;
                    stack_err_set_s = 1'b1;
                end else begin
                    upc_next_s = stack_mem[sp_r - SP_W'(1)];
                    sp_next_s  = sp_r - SP_W'(1);
                end
            end
            OP_FETCH: begin
                upc_next_s = '0;
                sp_next_s  = '0;
            end
            default: upc_next_s = '0;
        endcase
    end

    // Sequencer state register; ld_en freezes everything, CLR beats both.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            upc_r       <= '0;
            sp_r        <= '0;
            stack_err_r <= 1'b0;
            moc_err_r   <= 1'b0;
        end else if (!ld_en) begin
            upc_r       <= upc_next_s;
            sp_r        <= sp_next_s;
            stack_err_r <= stack_err_r | stack_err_set_s;
            moc_err_r   <= moc_err_r | moc_err_set_s;
        end
    end

    // Control word is combinational from upc and suppressed during reset or load.
    always_comb begin
        ctrl_s = '0;
        if (CLR || ld_en) begin
            ctrl_s = '0;
        end else begin
            ctrl_s = word_s[CW_W-1:0];
        end
    end

    assign ctrl      = ctrl_s;
    assign upc       = upc_r;
    assign stack_err = stack_err_r;
    assign moc_err   = moc_err_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer (TIMEOUT=4 for the watchdog build).
module tb_micro_sequencer;

    localparam logic [2:0] INC = 3'd0, JUMP = 3'd1, DECODE = 3'd2, WAIT = 3'd3,
                           CSKIP = 3'd4, CALL = 3'd5, RET = 3'd6, FETCH = 3'd7;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        moc = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [3:0]  flags = 4'h0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h0;
    logic [58:0] ld_data = 59'h0;
    logic [47:0] ctrl;
    logic [7:0]  upc;
    logic        stack_err;
    logic        moc_err;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    micro_sequencer #(
        .CW_W(48), .UADDR_W(8), .STACK_DEPTH(4), .DEC_BASE(32'h40), .TIMEOUT(4)
    ) dut (
        .CLK(CLK), .CLR(CLR), .moc(moc), .ir(ir), .flags(flags),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ctrl(ctrl), .upc(upc), .stack_err(stack_err), .moc_err(moc_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [2:0] op, input logic [7:0] nx,
                      input logic [47:0] cw);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = {op, nx, cw};
        tick();
        ld_en = 1'b0;
    endtask

    task automatic restart();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        // Reset behaviour
        tick();
        ld(8'h00, INC, 8'h00, 48'hA5);
        tick();
        chk("rst_upc", {56'h0, upc}, 64'h0);
        chk("rst_ctrl", {16'h0, ctrl}, 64'h0);
        chk("rst_serr", {63'h0, stack_err}, 64'h0);
        CLR = 1'b0;
        #1;
        chk("rel_ctrl", {16'h0, ctrl}, 64'hA5);
        tick();
        chk("rel_upc", {56'h0, upc}, 64'h1);

        // DECODE dispatch, including wrap
        CLR = 1'b1;
        ld(8'h00, DECODE, 8'h00, 48'h11);
        ir = 32'hE201_0000;
        restart();
        tick();
        chk("dec_60", {56'h0, upc}, 64'h60);
        ir = 32'hEC00_0000;
        restart();
        tick();
        chk("dec_wrap", {56'h0, upc}, 64'h00);

        // WAIT on moc
        CLR = 1'b1;
        ld(8'h00, INC, 8'h00, 48'h0);
        ld(8'h01, WAIT, 8'h33, 48'h0);
        ld(8'h02, FETCH, 8'h00, 48'h0);
        moc = 1'b0;
        restart();
        tick();
        chk("wait_enter", {56'h0, upc}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_hold", {56'h0, upc}, 64'h1);
        end
        moc = 1'b1;
        tick();
        chk("wait_done", {56'h0, upc}, 64'h2);
        restart();
        tick();
        tick();
        chk("wait_fast", {56'h0, upc}, 64'h2);
        moc = 1'b0;

        // CSKIP condition tests
        CLR = 1'b1;
        ld(8'h00, CSKIP, 8'h10, 48'h0);
        ir = 32'h0000_0000; flags = 4'b0000; restart(); tick();
        chk("eq_fail", {56'h0, upc}, 64'h10);
        ir = 32'h0000_0000; flags = 4'b0100; restart(); tick();
        chk("eq_pass", {56'h0, upc}, 64'h01);
        ir = 32'hE000_0000; flags = 4'b0000; restart(); tick();
        chk("al_pass", {56'h0, upc}, 64'h01);
        ir = 32'hF000_0000; flags = 4'b0100; restart(); tick();
        chk("nv_fail", {56'h0, upc}, 64'h10);
        ir = 32'hC000_0000; flags = 4'b1001; restart(); tick();
        chk("gt_pass", {56'h0, upc}, 64'h01);
        ir = 32'hB000_0000; flags = 4'b1001; restart(); tick();
        chk("lt_fail", {56'h0, upc}, 64'h10);

        // Nested CALLs: overflow on the fifth, then unwind
        CLR = 1'b1;
        ld(8'h00, CALL, 8'h10, 48'h0);
        ld(8'h10, CALL, 8'h20, 48'h0);
        ld(8'h20, CALL, 8'h30, 48'h0);
        ld(8'h30, CALL, 8'h40, 48'h0);
        ld(8'h40, CALL, 8'h50, 48'h0);
        ld(8'h50, RET, 8'h00, 48'h0);
        ld(8'h31, RET, 8'h00, 48'h0);
        ld(8'h21, RET, 8'h00, 48'h0);
        ld(8'h11, RET, 8'h00, 48'h0);
        ld(8'h01, RET, 8'h00, 48'h0);
        restart();
        tick(); tick(); tick(); tick();
        chk("call4_upc", {56'h0, upc}, 64'h40);
        chk("call4_serr", {63'h0, stack_err}, 64'h0);
        tick();
        chk("call5_upc", {56'h0, upc}, 64'h50);
        chk("call5_serr", {63'h0, stack_err}, 64'h1);
        tick();
        chk("ret1", {56'h0, upc}, 64'h31);
        tick();
        chk("ret2", {56'h0, upc}, 64'h21);
        tick();
        chk("ret3", {56'h0, upc}, 64'h11);
        tick();
        chk("ret4", {56'h0, upc}, 64'h01);
        tick();
        chk("ret5_empty", {56'h0, upc}, 64'h00);

        // FETCH clears stack; ld_en freezes; underflow sets stack_err
        CLR = 1'b1;
        ld(8'h00, CALL, 8'h08, 48'h0);
        ld(8'h08, FETCH, 8'h00, 48'h0);
        restart();
        tick();
        chk("fc_call", {56'h0, upc}, 64'h08);
        tick();
        chk("fc_fetch", {56'h0, upc}, 64'h00);
        chk("fc_serr0", {63'h0, stack_err}, 64'h0);
        ld_en = 1'b1; ld_addr = 8'h00; ld_data = {RET, 8'h00, 48'h0};
        #1;
        chk("ld_ctrl0", {16'h0, ctrl}, 64'h0);
        tick();
        ld_en = 1'b0;
        chk("ld_hold", {56'h0, upc}, 64'h00);
        tick();
        chk("uf_upc", {56'h0, upc}, 64'h00);
        chk("uf_serr", {63'h0, stack_err}, 64'h1);

        // moc watchdog
        CLR = 1'b1;
        ld(8'h00, JUMP, 8'h05, 48'h0);
        ld(8'h05, WAIT, 8'hF0, 48'h77);
        ld(8'hF0, JUMP, 8'hF0, 48'h0);
        moc = 1'b0;
        restart();
        tick();
        chk("wd_enter", {56'h0, upc}, 64'h05);
        tick(); tick(); tick(); tick();
        chk("wd_pre_upc", {56'h0, upc}, 64'h05);
        chk("wd_pre_err", {63'h0, moc_err}, 64'h0);
        tick();
`ifdef MOC_WATCHDOG_EN
        chk("wd_trap_upc", {56'h0, upc}, 64'hF0);
        chk("wd_trap_err", {63'h0, moc_err}, 64'h1);
`else
        chk("wd_none_upc", {56'h0, upc}, 64'h05);
        chk("wd_none_err", {63'h0, moc_err}, 64'h0);
`endif
        CLR = 1'b1;
        tick();
        chk("wd_clr_err", {63'h0, moc_err}, 64'h0);
        CLR = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
